// File: rtl/seg_pkg.sv
// Shared constants and the hex-to-seven-segment decode table for the display scan controller.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_NONE   = 4'hF;

  typedef logic [1:0] digit_idx_t;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] segs;
    segs = SEG_BLANK;
    case (nibble)
      4'h0: segs = 7'h40;
      4'h1: segs = 7'h79;
      4'h2: segs = 7'h24;
      4'h3: segs = 7'h30;
      4'h4: segs = 7'h19;
      4'h5: segs = 7'h12;
      4'h6: segs = 7'h02;
      4'h7: segs = 7'h78;
      4'h8: segs = 7'h00;
      4'h9: segs = 7'h10;
      4'hA: segs = 7'h08;
      4'hB: segs = 7'h03;
      4'hC: segs = 7'h46;
      4'hD: segs = 7'h21;
      4'hE: segs = 7'h06;
      4'hF: segs = 7'h0E;
      default: segs = SEG_BLANK;
    endcase
    return segs;
  endfunction

endpackage

// File: rtl/seg_scan_tick.sv
// Slot timer and digit index for the display scan; flags the blanking window and frame start.
module seg_scan_tick
  import seg_pkg::*;
#(
  parameter int SLOT         = 25_000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  output digit_idx_t idx,
  output logic       blank,
  output logic       frame_wrap
);

  localparam int CW = (SLOT > 2) ? $clog2(SLOT) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0] slot_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      slot_cnt <= slot_cnt + CW'(1);
    end
  end

  assign blank      = (slot_cnt < BLANK_END);
  assign frame_wrap = (slot_cnt == '0) && (idx == 2'd0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with per-frame input shadowing
// and a dark gap at the start of every digit slot to suppress ghosting.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int REFRESH_HZ   = 1_000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_start
);

  localparam int SLOT = CLK_HZ / (4 * REFRESH_HZ);

  if (SLOT < 2) begin : g_bad_slot
    $error("seg_scan_ctrl: SLOT must be at least 2");
  end
  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= SLOT) begin : g_bad_blank
    $error("seg_scan_ctrl: BLANK_CYCLES must be in 1..SLOT-1");
  end

  digit_idx_t  idx;
  logic        blank;
  logic        frame_wrap;

  logic [15:0] shadow_val;
  logic [3:0]  shadow_dp;
  logic [3:0]  shadow_en;

  logic [6:0]  seg_next;
  logic        dp_next;
  logic [3:0]  an_next;

  seg_scan_tick #(
    .SLOT        (SLOT),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx       (idx),
    .blank     (blank),
    .frame_wrap(frame_wrap)
  );

  // Inputs are sampled once per frame so a display update never tears mid-scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val  <= '0;
      shadow_dp   <= '0;
      shadow_en   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_wrap;
      if (frame_wrap) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
        shadow_en  <= digit_en;
      end
    end
  end

  always_comb begin
    seg_next = SEG_BLANK;
    dp_next  = 1'b1;
    an_next  = AN_NONE;
    if (!blank && shadow_en[idx]) begin
      an_next  = ~(4'b0001 << idx);
      seg_next = seg_decode(shadow_val[{idx, 2'b00} +: 4]);
      dp_next  = ~shadow_dp[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= AN_NONE;
    end else begin
      seg <= seg_next;
      dp  <= dp_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SLOT=10, two blanking cycles, 40-cycle frames.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  digit_en = 4'h0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] val_m = 16'h0000;
  logic [3:0]  dp_m = 4'h0;
  logic [3:0]  en_m = 4'h0;

  logic [6:0] seg_tbl [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_ctrl #(
    .CLK_HZ      (4000),
    .REFRESH_HZ  (100),
    .BLANK_CYCLES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // One clock of scanning: advance, update the frame-shadow model, compare all pins.
  task automatic apply_stimulus(input int n);
    int s, slot, d;
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      s    = cyc - 1;
      slot = s % 10;
      d    = (s / 10) % 4;
      if (s % 40 == 0) begin
        val_m = value;
        dp_m  = dp_in;
        en_m  = digit_en;
      end
      an_e  = 4'hF;
      seg_e = 7'h7F;
      dp_e  = 1'b1;
      if (slot >= 2 && en_m[d]) begin
        an_e[d] = 1'b0;
        seg_e   = seg_tbl[val_m[4*d +: 4]];
        dp_e    = ~dp_m[d];
      end
      check_output("an", {3'b000, an}, {3'b000, an_e});
      check_output("seg", seg, seg_e);
      check_output("dp", {6'd0, dp}, {6'd0, dp_e});
      check_output("frame_start", {6'd0, frame_start}, {6'd0, (s % 40 == 0)});
      checks++;
      assert ($countones(~an) <= 1)
      else begin
        errors++;
        $error("[TB] FAIL onehot cyc=%0d: observed an=%h required at most one low", cyc, an);
      end
    end
  endtask

  initial begin
    value    = 16'h1234;
    dp_in    = 4'h0;
    digit_en = 4'hF;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_an", {3'b000, an}, 7'h0F);
    check_output("rst_seg", seg, 7'h7F);
    check_output("rst_dp", {6'd0, dp}, 7'h01);
    check_output("rst_frame_start", {6'd0, frame_start}, 7'h00);

    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;

    // Frame 1 shows 1234; spot-check digit 0 by hand.
    apply_stimulus(5);
    check_output("d0_an", {3'b000, an}, 7'h0E);
    check_output("d0_seg", seg, 7'h19);
    apply_stimulus(35);

    // Change value mid-frame; the rest of this frame must still show 1234.
    apply_stimulus(15);
    value = 16'hABCD;
    apply_stimulus(25);

    // Frame 3 shows D,C,b,A; new enables/dp requested mid-frame.
    apply_stimulus(5);
    check_output("abcd_d0_seg", seg, 7'h21);
    apply_stimulus(15);
    digit_en = 4'b0101;
    dp_in    = 4'b0100;
    apply_stimulus(20);

    // Frame 4: digits 1,3 dark, digit 2 with its decimal point.
    apply_stimulus(25);
    check_output("en_d2_an", {3'b000, an}, 7'h0B);
    check_output("en_d2_dp", {6'd0, dp}, 7'h00);
    apply_stimulus(15);

    for (int f = 0; f < 10; f++) begin
      value    = 16'h5678 ^ 16'(f * 16'h1357);
      digit_en = 4'hF ^ 4'(f);
      dp_in    = 4'(f * 3);
      apply_stimulus(40);
    end

    // Reset during digit 2, then confirm a fresh restart at digit 0.
    value    = 16'h1234;
    digit_en = 4'hF;
    dp_in    = 4'h0;
    apply_stimulus(25);
    check_output("pre_rst_an", {3'b000, an}, 7'h0B);
    rst_n = 1'b0;
    #1;
    check_output("midrst_an", {3'b000, an}, 7'h0F);
    check_output("midrst_seg", seg, 7'h7F);
    check_output("midrst_dp", {6'd0, dp}, 7'h01);
    value = 16'h9ABC;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    apply_stimulus(5);
    check_output("restart_d0_seg", seg, 7'h46);
    apply_stimulus(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
